// File: rtl/zap_divide.sv
// zap_divide: iterative radix-2 restoring divider, signed/unsigned, start/busy/done handshake
// Ports:
//   i_clk, i_reset (sync, active-high), i_clear (abort to IDLE, results held)
//   i_start, i_signed, i_dividend, i_divisor: request and operands, sampled in IDLE
//   o_quotient, o_remainder, o_div_by_zero: registered result, updated when leaving FIX
//   o_busy: state != IDLE; o_done: one-cycle pulse with each new result
module zap_divide #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] dvs, rem, quo, dvd_abs, dvs_abs;
  logic [CW-1:0] cnt;
  logic q_neg, r_neg, div0, dvd_neg, dvs_neg, zero_dvs, go;
  logic [WIDTH:0] trial;
  assign dvd_neg = i_signed & i_dividend[WIDTH-1];
  assign dvs_neg = i_signed & i_divisor[WIDTH-1];
  assign dvd_abs = dvd_neg ? -i_dividend : i_dividend;
  assign dvs_abs = dvs_neg ? -i_divisor : i_divisor;
  assign zero_dvs = i_divisor == '0;
  assign go = !i_clear && state == IDLE && i_start;
  // rem < dvs always holds, so the shifted partial remainder fits WIDTH+1 bits
  assign trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};
  assign o_busy = state != IDLE;
  always_ff @(posedge i_clk)
    state <= i_reset ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = i_clear ? IDLE :
                state == IDLE ? (i_start ? (zero_dvs ? FIX : CALC) : IDLE) :
                state == CALC ? (cnt == '0 ? FIX : CALC) : IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      dvs <= '0;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      div0 <= 1'b0;
      o_quotient <= '0;
      o_remainder <= '0;
      o_div_by_zero <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (go) begin
        // on divide-by-zero quo carries the raw dividend through to the remainder output
        quo <= zero_dvs ? i_dividend : dvd_abs;
        dvs <= dvs_abs;
        rem <= '0;
        cnt <= CW'(WIDTH - 1);
        q_neg <= dvd_neg ^ dvs_neg;
        r_neg <= dvd_neg;
        div0 <= zero_dvs;
      end
      if (!i_clear && state == CALC) begin
        rem <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
        cnt <= cnt - CW'(1);
      end
      if (!i_clear && state == FIX) begin
        o_quotient <= div0 ? '1 : q_neg ? -quo : quo;
        o_remainder <= div0 ? quo : r_neg ? -rem : rem;
        o_div_by_zero <= div0;
        o_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_zap_divide.sv
// tb_zap_divide: directed-vector self-checking bench for zap_divide
module tb_zap_divide;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0, start = 1'b0, sgn = 1'b0;
  logic [31:0] dvd = '0, dvs = '0, q, r;
  logic busy, done, dz;
  int n_chk = 0, n_err = 0;
  int lat, bcyc, dn;
  zap_divide #(.WIDTH(32)) dut (
    .i_clk(clk), .i_reset(rst), .i_clear(clr), .i_start(start), .i_signed(sgn),
    .i_dividend(dvd), .i_divisor(dvs), .o_quotient(q), .o_remainder(r),
    .o_busy(busy), .o_done(done), .o_div_by_zero(dz)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // called on a negedge; returns on the negedge where o_done is seen
  // poke >= 0 raises a stray i_start with other operands at that busy cycle
  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b, input int poke);
    sgn = s; dvd = a; dvs = b; start = 1'b1;
    @(posedge clk);
    lat = 0; bcyc = 0;
    forever begin
      @(negedge clk);
      start = lat == poke;
      if (lat == poke) begin dvd = 32'd50; dvs = 32'd5; end
      if (busy) bcyc++;
      if (done) break;
      if (lat > 100) begin chk("timeout", 32'(lat), 32'd33); break; end
      @(posedge clk);
      lat++;
    end
    start = 1'b0;
  endtask
  task automatic res(input string tag, input logic [31:0] eq, input logic [31:0] er, input logic ez);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_r"}, r, er);
    chk({tag, "_dz"}, 32'(dz), 32'(ez));
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_q", q, 0); chk("rst_r", r, 0); chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0); chk("rst_dz", 32'(dz), 0);
    rst = 1'b0;
    @(negedge clk);
    run(0, 100, 7, -1);
    res("u100_7", 14, 2, 0); chk("u100_7_lat", 32'(lat), 33); chk("u100_7_busy", 32'(bcyc), 33);
    run(1, -32'sd7, 2, -1);   res("sm7_2", 32'hFFFFFFFD, 32'hFFFFFFFF, 0);
    run(1, 7, -32'sd2, -1);   res("s7_m2", 32'hFFFFFFFD, 1, 0);
    run(1, -32'sd7, -32'sd2, -1); res("sm7_m2", 3, 32'hFFFFFFFF, 0);
    run(0, 32'hFFFFFFF9, 2, -1); res("uF9_2", 32'h7FFFFFFC, 1, 0);
    run(1, 32'h1234, 0, -1);  res("s_dz", 32'hFFFFFFFF, 32'h1234, 1); chk("s_dz_lat", 32'(lat), 1);
    run(0, 32'h1234, 0, -1);  res("u_dz", 32'hFFFFFFFF, 32'h1234, 1); chk("u_dz_lat", 32'(lat), 1);
    run(1, 32'h80000000, 32'hFFFFFFFF, -1); res("s_ovf", 32'h80000000, 0, 0);
    run(0, 32'hFFFFFFFF, 1, -1); res("u_max", 32'hFFFFFFFF, 0, 0);
    // abort at CALC cycle 10: results stay at the previous 0xFFFFFFFF/1 values
    sgn = 0; dvd = 100; dvs = 7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("clr_busy", 32'(busy), 0); chk("clr_done", 32'(done), 0);
    res("clr_hold", 32'hFFFFFFFF, 0, 0);
    dn = 0;
    repeat (40) @(negedge clk) if (done) dn++;
    chk("clr_no_done", 32'(dn), 0);
    clr = 1'b1; start = 1'b1; dvd = 9; dvs = 3;
    @(negedge clk); clr = 1'b0; start = 1'b0;
    chk("clr_start_busy", 32'(busy), 0);
    repeat (40) @(negedge clk) if (done) dn++;
    chk("clr_start_no_done", 32'(dn), 0);
    run(0, 50, 5, -1); res("u50_5", 10, 0, 0);
    run(0, 100, 7, 5); res("poke", 14, 2, 0); chk("poke_lat", 32'(lat), 33);
    chk("b2b_done", 32'(done), 1);
    run(0, 1000, 33, -1); res("b2b", 30, 10, 0); chk("b2b_lat", 32'(lat), 33);
    sgn = 1; dvd = 77; dvs = 3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    res("rst_mid", 0, 0, 0); chk("rst_mid_busy", 32'(busy), 0); chk("rst_mid_done", 32'(done), 0);
    dn = 0;
    repeat (40) @(negedge clk) if (done) dn++;
    chk("rst_mid_no_done", 32'(dn), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
